// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes,
// FSM state encoding, default iteration count and the op decoder helpers.
package muldiv_pkg;

  localparam int unsigned CALC_CYCLES_DEF = 32;

  localparam logic [31:0] OPC_MUL    = 32'd10;
  localparam logic [31:0] OPC_MULH   = 32'd11;
  localparam logic [31:0] OPC_MULHSU = 32'd12;
  localparam logic [31:0] OPC_MULHU  = 32'd13;
  localparam logic [31:0] OPC_DIV    = 32'd14;
  localparam logic [31:0] OPC_DIVU   = 32'd15;
  localparam logic [31:0] OPC_REM    = 32'd16;
  localparam logic [31:0] OPC_REMU   = 32'd17;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  // Bit 2 set marks the divide family, bits 2:1 both set mark remainders.
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  function automatic logic op_valid(input logic [31:0] instr);
    return (instr >= OPC_MUL) && (instr <= OPC_REMU);
  endfunction

  // Codes 10..17 map onto 0..7 by their low three bits minus 2 (mod 8).
  function automatic op_e op_decode(input logic [2:0] instr_lo);
    return op_e'(instr_lo - 3'd2);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up in a final FIX state.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CALC_CYCLES = CALC_CYCLES_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic [4:0]      i_rd,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_load_regfile
);

  localparam int CW = $clog2(CALC_CYCLES + 1);

  state_e          r_state;
  op_e             r_op;
  logic [XLEN-1:0] r_hi, r_lo, r_opb;
  logic            r_neg_a, r_neg_q, r_fast;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_rd_cap;
  logic            r_busy, r_done;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd;

  op_e             w_op;
  logic            w_accept, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b;
  logic            w_is_div, w_div0, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_fast_q, w_fast_r;
  logic [XLEN:0]   w_sum, w_shift, w_diff;
  logic            w_q_bit;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

  assign w_op     = op_decode(i_instruction[2:0]);
  assign w_accept = i_start && !i_kill && op_valid(i_instruction) &&
                    (r_state == IDLE || r_state == DONE);
  assign w_a_sgn  = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                    (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_sgn  = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                    (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_neg_a  = w_a_sgn && i_A[XLEN-1];
  assign w_neg_b  = w_b_sgn && i_B[XLEN-1];
  assign w_mag_a  = w_neg_a ? -i_A : i_A;
  assign w_mag_b  = w_neg_b ? -i_B : i_B;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_is_div = w_op[2];
  assign w_div0   = w_is_div && (i_B == '0);
  assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                    (i_A == {1'b1, {(XLEN-1){1'b0}}}) && (i_B == '1);
  assign w_fast_q = w_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  assign w_fast_r = w_div0 ? i_A : '0;

  // Multiply: r_hi accumulates, r_lo holds the multiplier shifting out LSB-first.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};
  assign w_q_bit = !w_diff[XLEN];

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -r_lo : r_lo;
  assign w_rem    = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                         w_fix_res = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                w_fix_res = r_fast ? r_lo : w_quo;
      OP_REM, OP_REMU:                w_fix_res = r_fast ? r_hi : w_rem;
      default:                        w_fix_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_fast   <= 1'b0;
      r_cnt    <= '0;
      r_rd_cap <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_kill) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (w_accept) begin
              r_state  <= CALC;
              r_busy   <= 1'b1;
              r_op     <= w_op;
              r_rd_cap <= i_rd;
              r_neg_a  <= w_neg_a;
              r_neg_q  <= w_neg_a ^ w_neg_b;
              r_fast   <= w_div0 || w_ovf;
              r_cnt    <= '0;
              // Both algorithms start with r_hi=0 and the shifting operand in r_lo.
              r_hi     <= (w_div0 || w_ovf) ? w_fast_r : '0;
              r_lo     <= (w_div0 || w_ovf) ? w_fast_q : (w_is_div ? w_mag_a : w_mag_b);
              r_opb    <= w_is_div ? w_mag_b : w_mag_a;
            end else begin
              r_state <= IDLE;
            end
          end
          CALC: begin
            if (r_fast) begin
              r_state <= FIX;
            end else begin
              if (r_op[2]) begin
                r_hi <= w_q_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_q_bit};
              end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
              end
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == CW'(CALC_CYCLES - 1)) r_state <= FIX;
            end
          end
          FIX: begin
            r_result <= w_fix_res;
            r_rd     <= r_rd_cap;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_load_regfile = r_done;
  assign o_result       = r_result;
  assign o_rd           = r_rd;

endmodule
